// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction channel plus downstream immediate channel.
// illegal_o exists only when IMM_GEN_ILLEGAL_CHK_EN is defined.
interface imm_gen_pipe_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic            ready_o;
   logic [31:0]     instr_i;
   logic            valid_o;
   logic            ready_i;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] imm_o;
   logic [2:0]      fmt_o;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
   logic            illegal_o;
`endif

   modport slave (
      input  valid_i, instr_i, ready_i,
      output ready_o, valid_o, instr_o, imm_o, fmt_o
`ifdef IMM_GEN_ILLEGAL_CHK_EN
      , output illegal_o
`endif
   );

   modport master (
      output valid_i, instr_i, ready_i,
      input  ready_o, valid_o, instr_o, imm_o, fmt_o
`ifdef IMM_GEN_ILLEGAL_CHK_EN
      , input  illegal_o
`endif
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Elastic pipelined RV32I/RV64I immediate generator with STAGES valid/ready register stages.
// Optional unknown-opcode flag (illegal_o) enabled by defining IMM_GEN_ILLEGAL_CHK_EN.
module imm_gen_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         flush_i,
   imm_gen_pipe_if.slave bus
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_J    = 3'd1;
   localparam logic [2:0] FMT_U    = 3'd2;
   localparam logic [2:0] FMT_S    = 3'd3;
   localparam logic [2:0] FMT_B    = 3'd4;
   localparam logic [2:0] FMT_I    = 3'd5;

   logic [31:0]     instr_w;
   logic [6:0]      opcode;
   logic [2:0]      fmt_dec;
   logic [31:0]     imm32_dec;
   logic [XLEN-1:0] imm_dec;

   assign instr_w = bus.instr_i;
   assign opcode  = instr_w[6:0];

   always_comb begin
      fmt_dec   = FMT_NONE;
      imm32_dec = '0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
            fmt_dec   = FMT_I;
            imm32_dec = {{20{instr_w[31]}}, instr_w[31:20]};
         end
         OP_IMM32: begin
            if (XLEN == 64) begin
               fmt_dec   = FMT_I;
               imm32_dec = {{20{instr_w[31]}}, instr_w[31:20]};
            end
         end
         OP_STORE: begin
            fmt_dec   = FMT_S;
            imm32_dec = {{20{instr_w[31]}}, instr_w[31:25], instr_w[11:7]};
         end
         OP_BRANCH: begin
            fmt_dec   = FMT_B;
            imm32_dec = {{19{instr_w[31]}}, instr_w[31], instr_w[7],
                         instr_w[30:25], instr_w[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt_dec   = FMT_U;
            imm32_dec = {instr_w[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt_dec   = FMT_J;
            imm32_dec = {{11{instr_w[31]}}, instr_w[31], instr_w[19:12],
                         instr_w[20], instr_w[30:21], 1'b0};
         end
         default: begin
            fmt_dec   = FMT_NONE;
            imm32_dec = '0;
         end
      endcase
   end

   // Every 32-bit immediate is already sign-extended, so widening to XLEN is a signed cast.
   assign imm_dec = XLEN'($signed(imm32_dec));

`ifdef IMM_GEN_ILLEGAL_CHK_EN
   logic rtype_dec;
   logic illegal_dec;
   assign rtype_dec   = (opcode == 7'b0110011) || ((XLEN == 64) && (opcode == 7'b0111011));
   assign illegal_dec = (fmt_dec == FMT_NONE) && !rtype_dec;
`endif

   logic [STAGES-1:0] valid_q, valid_d;
   logic [31:0]       instr_q [STAGES];
   logic [31:0]       instr_d [STAGES];
   logic [XLEN-1:0]   imm_q   [STAGES];
   logic [XLEN-1:0]   imm_d   [STAGES];
   logic [2:0]        fmt_q   [STAGES];
   logic [2:0]        fmt_d   [STAGES];
`ifdef IMM_GEN_ILLEGAL_CHK_EN
   logic [STAGES-1:0] illegal_q, illegal_d;
`endif
   logic [STAGES:0]   adv;

   // A stage advances when empty or when the stage after it advances; the tail follows ready_i.
   always_comb begin
      adv[STAGES] = bus.ready_i;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = !valid_q[k] || adv[k+1];
      end
   end

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      imm_d   = imm_q;
      fmt_d   = fmt_q;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
      illegal_d = illegal_q;
`endif
      if (flush_i) begin
         valid_d = '0;
      end else begin
         if (adv[0]) begin
            valid_d[0] = bus.valid_i;
            if (bus.valid_i) begin
               instr_d[0] = instr_w;
               imm_d[0]   = imm_dec;
               fmt_d[0]   = fmt_dec;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
               illegal_d[0] = illegal_dec;
`endif
            end
         end
         for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               valid_d[k] = valid_q[k-1];
               if (valid_q[k-1]) begin
                  instr_d[k] = instr_q[k-1];
                  imm_d[k]   = imm_q[k-1];
                  fmt_d[k]   = fmt_q[k-1];
`ifdef IMM_GEN_ILLEGAL_CHK_EN
                  illegal_d[k] = illegal_q[k-1];
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            instr_q[k] <= '0;
            imm_q[k]   <= '0;
            fmt_q[k]   <= '0;
         end
`ifdef IMM_GEN_ILLEGAL_CHK_EN
         illegal_q <= '0;
`endif
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
         fmt_q   <= fmt_d;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   assign bus.ready_o = adv[0];
   assign bus.valid_o = valid_q[STAGES-1];
   assign bus.instr_o = instr_q[STAGES-1];
   assign bus.imm_o   = imm_q[STAGES-1];
   assign bus.fmt_o   = fmt_q[STAGES-1];
`ifdef IMM_GEN_ILLEGAL_CHK_EN
   assign bus.illegal_o = illegal_q[STAGES-1];
`endif

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, elastic immediate generator for the decode stage, successor to the combinational `imm_gen`. Classifies every RV32I/RV64I base opcode into I, S, B, U or J format. Produces the sign-extended immediate at a parametrised width (`XLEN`) through `STAGES` registered valid/ready stages, so decode can absorb fetch bubbles and execute stalls.

## Interface
- `XLEN`, default 32: immediate output width; legal values are 32 and 64.
- `STAGES`, default 1: number of registered pipeline stages; legal range is 1 to 4.

- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_n_i`  input  1  reset, asynchronous, active-low.
- `flush_i`  input  1  synchronous kill of all in-flight entries.
- `valid_i`  input  1  `instr_i` is valid this cycle.
- `ready_o`  output  1  block accepts `instr_i` this cycle.
- `instr_i`  input  32  instruction word.
- `valid_o`  output  1  output entry is valid.
- `ready_i`  input  1  downstream accepts the output entry.
- `instr_o`  output  32  instruction word carried with the entry.
- `imm_o`  output  XLEN  sign-extended immediate.
- `fmt_o`  output  3  format code: 0 = none/R, 1 = J, 2 = U, 3 = S, 4 = B, 5 = I.
- `illegal_o`  output  1  unknown opcode; present only with `IMM_GEN_ILLEGAL_CHK_EN`.

## Operation
Decode is combinational on `instr_i` and is registered into stage 0. Stages 1 to `STAGES-1` are pure valid/data registers.

Opcode map on `instr_i[6:0]`:
- I format: 0000011, 0010011, 1100111, 0001111, 1110011; when `XLEN`=64, also 0011011.
- S format: 0100011.
- B format: 1100011.
- U format: 0110111, 0010111.
- J format: 1101111.
- 0110011 (R-type), and 0111011 when `XLEN`=64: `fmt_o`=0, `imm_o`=0.
- Any other opcode: `fmt_o`=0, `imm_o`=0.

Immediate construction, each result sign-extended from `instr[31]` to `XLEN`:
- I: `instr[31:20]`.
- S: `{instr[31:25], instr[11:7]}`.
- B: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`.
- U: `{instr[31:12], 12'b0}`.
- J: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`.

Elastic pipeline:
- Stage k advances when it is empty or stage k+1 advances; the last stage advances on `ready_i`.
- `ready_o` is stage 0's advance signal, computed combinationally through the chain. There is no combinational path from `instr_i` to any output.
- Transfer in: `valid_i && ready_o`. Transfer out: `valid_o && ready_i`.
- While `valid_o && !ready_i`, `valid_o`, `instr_o`, `imm_o`, `fmt_o` and `illegal_o` hold stable.
- Data registers load only on transfer. A valid register clears when its contents move on and nothing replaces them.

Flush:
- `flush_i` clears every valid bit on the next edge.
- An input presented in the same cycle as `flush_i` is dropped, even if `ready_o`=1.
- Flush has priority over every transfer.

Reset, asynchronous and active-low:
- All valid bits are 0, and `valid_o`=0.
- All data registers are 0, so `imm_o`=0, `fmt_o`=0, `instr_o`=0, `illegal_o`=0.
- `ready_o`=1 because the pipeline is empty.
- Reset asserted mid-stream discards all entries immediately.

## Timing
- Latency: an entry accepted at edge N appears on `valid_o` after edge N+`STAGES-1`. With `STAGES`=1 it is visible in the cycle after acceptance.
- Throughput: one entry per cycle while `ready_i`=1.
- Capacity: `STAGES` entries. With a full pipeline and `ready_i`=0, `ready_o`=0.
- Full pipeline with `ready_i`=1 and `valid_i`=1: the output and input transfer in the same cycle with no bubble.
- `ready_o` may depend combinationally on `ready_i`. Downstream must not make `ready_i` depend on `ready_o`.

## Configuration
- `IMM_GEN_ILLEGAL_CHK_EN` defined:
  - `illegal_o` port exists.
  - It is registered with the entry and equals 1 for any opcode outside the map above, including bits[1:0]≠11.
  - For R-type opcodes it is 0.
- Not defined: the port and its logic are absent. Unknown opcodes still give `fmt_o`=0, `imm_o`=0.

## Test plan
- B-type, `XLEN`=32: BEQ `instr_i`=0xFE000EE3 -> `fmt_o`=4, `imm_o`=0xFFFFFFFC. Then 10,000 random B immediates are checked against the formula with 0 errors.
- S/U/J coverage:
  - 0xFE002FA3 -> `fmt_o`=3, `imm_o`=0xFFFFFFFF.
  - 0x123450B7 -> `fmt_o`=2, `imm_o`=0x12345000.
  - 0x0010006F -> `fmt_o`=1, `imm_o`=0x00000800.
- `XLEN`=64: 0x800000B7 -> `imm_o`=0xFFFFFFFF80000000. 0x0011009B (ADDIW, imm 1) -> `fmt_o`=5, `imm_o`=1.
- Backpressure, `STAGES`=3:
  - Stream 5 instructions with `ready_i`=0: `ready_o` falls after 3 accepts.
  - Release `ready_i`: all 5 emerge in order, unchanged, with outputs stable while stalled.
- Flush/reset:
  - With 2 entries in flight, pulse `flush_i` alongside a new `valid_i`: `valid_o`=0 next cycle and nothing emerges.
  - Assert `rst_n_i`=0 mid-cycle: `valid_o`=0 and `imm_o`=0 immediately, with `ready_o`=1.
- With `IMM_GEN_ILLEGAL_CHK_EN`: `instr_i`=0x00000000 -> `illegal_o`=1, `fmt_o`=0, `imm_o`=0. `instr_i`=0x00000033 -> `illegal_o`=0.
